// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal shift register: hold, load, logical/arithmetic shifts, rotates, clear,
// plus a shift counter that pulses Done after every WIDTH-th counted shift or rotate.
module universal_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic [2:0]       Mode,
  input  logic [WIDTH-1:0] D,
  input  logic             SerIn,
  output logic [WIDTH-1:0] Q,
  output logic             SerOut,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_LOAD  = 3'b001;
  localparam logic [2:0] MODE_SHR   = 3'b010;
  localparam logic [2:0] MODE_SHL   = 3'b011;
  localparam logic [2:0] MODE_ROR   = 3'b100;
  localparam logic [2:0] MODE_ROL   = 3'b101;
  localparam logic [2:0] MODE_ASR   = 3'b110;
  localparam logic [2:0] MODE_CLEAR = 3'b111;

  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_nxt_s;
  logic [CW-1:0]    cnt_inc_s;
  logic             cnt_wrap_s;
  logic [WIDTH-1:0] q_nxt_s;
  logic             ser_nxt_s;
  logic             done_nxt_s;

  // Count step shared by every shift/rotate mode; direction changes do not reset it
  always_comb begin
    cnt_wrap_s = (cnt_r == CW'(WIDTH - 1));
    cnt_inc_s  = cnt_wrap_s ? {CW{1'b0}} : (cnt_r + CW'(1));
  end

  // Next-state selection by mode; hold and disabled cycles keep everything but Done
  always_comb begin
    q_nxt_s    = Q;
    ser_nxt_s  = SerOut;
    cnt_nxt_s  = cnt_r;
    done_nxt_s = 1'b0;
    if (En) begin
      case (Mode)
        MODE_HOLD: begin
          q_nxt_s = Q;
        end
        MODE_LOAD: begin
          q_nxt_s   = D;
          cnt_nxt_s = {CW{1'b0}};
        end
        MODE_SHR: begin
          q_nxt_s    = {SerIn, Q[WIDTH-1:1]};
          ser_nxt_s  = Q[0];
          cnt_nxt_s  = cnt_inc_s;
          done_nxt_s = cnt_wrap_s;
        end
        MODE_SHL: begin
          q_nxt_s    = {Q[WIDTH-2:0], SerIn};
          ser_nxt_s  = Q[WIDTH-1];
          cnt_nxt_s  = cnt_inc_s;
          done_nxt_s = cnt_wrap_s;
        end
        MODE_ROR: begin
          q_nxt_s    = {Q[0], Q[WIDTH-1:1]};
          ser_nxt_s  = Q[0];
          cnt_nxt_s  = cnt_inc_s;
          done_nxt_s = cnt_wrap_s;
        end
        MODE_ROL: begin
          q_nxt_s    = {Q[WIDTH-2:0], Q[WIDTH-1]};
          ser_nxt_s  = Q[WIDTH-1];
          cnt_nxt_s  = cnt_inc_s;
          done_nxt_s = cnt_wrap_s;
        end
        MODE_ASR: begin
          q_nxt_s    = {Q[WIDTH-1], Q[WIDTH-1:1]};
          ser_nxt_s  = Q[0];
          cnt_nxt_s  = cnt_inc_s;
          done_nxt_s = cnt_wrap_s;
        end
        MODE_CLEAR: begin
          q_nxt_s   = {WIDTH{1'b0}};
          ser_nxt_s = 1'b0;
          cnt_nxt_s = {CW{1'b0}};
        end
        default: begin
          q_nxt_s = Q;
        end
      endcase
    end else begin
      q_nxt_s = Q;
    end
  end

  // Output and counter registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Q      <= {WIDTH{1'b0}};
      SerOut <= 1'b0;
      Done   <= 1'b0;
      cnt_r  <= {CW{1'b0}};
    end else begin
      Q      <= q_nxt_s;
      SerOut <= ser_nxt_s;
      Done   <= done_nxt_s;
      cnt_r  <= cnt_nxt_s;
    end
  end

endmodule

// File: tb/tb_universal_shift_reg.sv
// Table-driven bench for universal_shift_reg (WIDTH=8) with a scoreboard queue,
// plus serialise sequences on WIDTH=2 and WIDTH=13 instances.
module tb_universal_shift_reg;

  localparam logic [2:0] HOLD = 3'b000;
  localparam logic [2:0] LOAD = 3'b001;
  localparam logic [2:0] SHR  = 3'b010;
  localparam logic [2:0] SHL  = 3'b011;
  localparam logic [2:0] ROR  = 3'b100;
  localparam logic [2:0] ROL  = 3'b101;
  localparam logic [2:0] ASR  = 3'b110;
  localparam logic [2:0] CLR  = 3'b111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, serin, so, done;
  logic [2:0] mode;
  logic [7:0] d, q;

  logic        rst2, en2, serin2, so2, done2;
  logic [2:0]  mode2;
  logic [1:0]  d2, q2;
  logic        rst13, en13, serin13, so13, done13;
  logic [2:0]  mode13;
  logic [12:0] d13, q13;

  universal_shift_reg #(.WIDTH(8)) dut (
    .Clk(clk), .Reset(rst), .En(en), .Mode(mode), .D(d), .SerIn(serin),
    .Q(q), .SerOut(so), .Done(done));
  universal_shift_reg #(.WIDTH(2)) dut2 (
    .Clk(clk), .Reset(rst2), .En(en2), .Mode(mode2), .D(d2), .SerIn(serin2),
    .Q(q2), .SerOut(so2), .Done(done2));
  universal_shift_reg #(.WIDTH(13)) dut13 (
    .Clk(clk), .Reset(rst13), .En(en13), .Mode(mode13), .D(d13), .SerIn(serin13),
    .Q(q13), .SerOut(so13), .Done(done13));

  typedef struct {
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       serin;
    logic [7:0] q;
    logic       so;
    logic       done;
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic       so;
    logic       done;
    int         idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic void add(logic r, logic e, logic [2:0] m, logic [7:0] dd, logic s,
                              logic [7:0] eq, logic eso, logic edone);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.d = dd; v.serin = s;
    v.q = eq; v.so = eso; v.done = edone;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    logic [1:0]  pat2;
    logic [12:0] pat13;

    rst = 1'b1; en = 1'b0; mode = HOLD; d = 8'h00; serin = 1'b0;
    rst2 = 1'b1; en2 = 1'b0; mode2 = HOLD; d2 = 2'b00; serin2 = 1'b0;
    rst13 = 1'b1; en13 = 1'b0; mode13 = HOLD; d13 = 13'h0; serin13 = 1'b0;

    // Reset (second cycle also requests a load: reset must win), then load
    add(1'b1, 1'b0, HOLD, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    add(1'b1, 1'b1, LOAD, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0);
    add(1'b0, 1'b1, LOAD, 8'hA5, 1'b0, 8'hA5, 1'b0, 1'b0);
    // Serialise A5 right, SerIn=0
    add(1'b0, 1'b1, SHR, 8'h00, 1'b0, 8'h52, 1'b1, 1'b0);
    add(1'b0, 1'b1, SHR, 8'h00, 1'b0, 8'h29, 1'b0, 1'b0);
    add(1'b0, 1'b1, SHR, 8'h00, 1'b0, 8'h14, 1'b1, 1'b0);
    add(1'b0, 1'b1, SHR, 8'h00, 1'b0, 8'h0A, 1'b0, 1'b0);
    add(1'b0, 1'b1, SHR, 8'h00, 1'b0, 8'h05, 1'b0, 1'b0);
    add(1'b0, 1'b1, SHR, 8'h00, 1'b0, 8'h02, 1'b1, 1'b0);
    add(1'b0, 1'b1, SHR, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0);
    add(1'b0, 1'b1, SHR, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
    add(1'b0, 1'b1, HOLD, 8'h77, 1'b1, 8'h00, 1'b1, 1'b0);
    // Rotates and arithmetic shift
    add(1'b0, 1'b1, LOAD, 8'h81, 1'b0, 8'h81, 1'b1, 1'b0);
    add(1'b0, 1'b1, ROL, 8'h00, 1'b0, 8'h03, 1'b1, 1'b0);
    add(1'b0, 1'b1, ROR, 8'h00, 1'b0, 8'h81, 1'b1, 1'b0);
    add(1'b0, 1'b1, LOAD, 8'h80, 1'b0, 8'h80, 1'b1, 1'b0);
    add(1'b0, 1'b1, ASR, 8'h00, 1'b1, 8'hC0, 1'b0, 1'b0);
    add(1'b0, 1'b1, ASR, 8'h00, 1'b1, 8'hE0, 1'b0, 1'b0);
    add(1'b0, 1'b1, ASR, 8'h00, 1'b1, 8'hF0, 1'b0, 1'b0);
    // Pause: 5 shifts, 3 disabled cycles, 3 more shifts
    add(1'b0, 1'b1, LOAD, 8'h3C, 1'b0, 8'h3C, 1'b0, 1'b0);
    add(1'b0, 1'b1, SHL, 8'h00, 1'b1, 8'h79, 1'b0, 1'b0);
    add(1'b0, 1'b1, SHL, 8'h00, 1'b1, 8'hF3, 1'b0, 1'b0);
    add(1'b0, 1'b1, SHL, 8'h00, 1'b1, 8'hE7, 1'b1, 1'b0);
    add(1'b0, 1'b1, SHL, 8'h00, 1'b1, 8'hCF, 1'b1, 1'b0);
    add(1'b0, 1'b1, SHL, 8'h00, 1'b1, 8'h9F, 1'b1, 1'b0);
    add(1'b0, 1'b0, SHL, 8'h11, 1'b0, 8'h9F, 1'b1, 1'b0);
    add(1'b0, 1'b0, CLR, 8'h22, 1'b0, 8'h9F, 1'b1, 1'b0);
    add(1'b0, 1'b0, LOAD, 8'h33, 1'b1, 8'h9F, 1'b1, 1'b0);
    add(1'b0, 1'b1, SHL, 8'h00, 1'b0, 8'h3E, 1'b1, 1'b0);
    add(1'b0, 1'b1, SHL, 8'h00, 1'b0, 8'h7C, 1'b0, 1'b0);
    add(1'b0, 1'b1, SHL, 8'h00, 1'b0, 8'hF8, 1'b0, 1'b1);
    // Abort: 5 shifts, load, 8 rotates
    add(1'b0, 1'b1, SHR, 8'h00, 1'b1, 8'hFC, 1'b0, 1'b0);
    add(1'b0, 1'b1, SHR, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0);
    add(1'b0, 1'b1, SHR, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0);
    add(1'b0, 1'b1, SHR, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    add(1'b0, 1'b1, SHR, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    add(1'b0, 1'b1, LOAD, 8'h5A, 1'b0, 8'h5A, 1'b1, 1'b0);
    add(1'b0, 1'b1, ROR, 8'h00, 1'b0, 8'h2D, 1'b0, 1'b0);
    add(1'b0, 1'b1, ROR, 8'h00, 1'b0, 8'h96, 1'b1, 1'b0);
    add(1'b0, 1'b1, ROR, 8'h00, 1'b0, 8'h4B, 1'b0, 1'b0);
    add(1'b0, 1'b1, ROR, 8'h00, 1'b0, 8'hA5, 1'b1, 1'b0);
    add(1'b0, 1'b1, ROR, 8'h00, 1'b0, 8'hD2, 1'b1, 1'b0);
    add(1'b0, 1'b1, ROR, 8'h00, 1'b0, 8'h69, 1'b0, 1'b0);
    add(1'b0, 1'b1, ROR, 8'h00, 1'b0, 8'hB4, 1'b1, 1'b0);
    add(1'b0, 1'b1, ROR, 8'h00, 1'b0, 8'h5A, 1'b0, 1'b1);
    // Clear, then 16 continuous left shifts filling ones
    add(1'b0, 1'b1, CLR, 8'hAA, 1'b1, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      logic [7:0] exp_q;
      exp_q = (i < 8) ? 8'((16'h1 << (i + 1)) - 16'h1) : 8'hFF;
      add(1'b0, 1'b1, SHL, 8'h00, 1'b1, exp_q, (i >= 8) ? 1'b1 : 1'b0,
          (i == 7 || i == 15) ? 1'b1 : 1'b0);
    end
    add(1'b0, 1'b1, HOLD, 8'h00, 1'b0, 8'hFF, 1'b1, 1'b0);
    // Reset after shift 4, then 8 shifts to Done
    add(1'b0, 1'b1, SHR, 8'h00, 1'b0, 8'h7F, 1'b1, 1'b0);
    add(1'b0, 1'b1, SHR, 8'h00, 1'b0, 8'h3F, 1'b1, 1'b0);
    add(1'b0, 1'b1, SHR, 8'h00, 1'b0, 8'h1F, 1'b1, 1'b0);
    add(1'b0, 1'b1, SHR, 8'h00, 1'b0, 8'h0F, 1'b1, 1'b0);
    add(1'b1, 1'b1, SHR, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      add(1'b0, 1'b1, SHL, 8'h00, 1'b1, 8'((16'h1 << (i + 1)) - 16'h1), 1'b0,
          (i == 7) ? 1'b1 : 1'b0);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      exp_t x;
      @(negedge clk);
      rst = vecs[i].rst; en = vecs[i].en; mode = vecs[i].mode;
      d = vecs[i].d; serin = vecs[i].serin;
      x.q = vecs[i].q; x.so = vecs[i].so; x.done = vecs[i].done; x.idx = i;
      sb.push_back(x);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("vec%0d Q", e.idx), 32'(q), 32'(e.q));
      chk($sformatf("vec%0d SerOut", e.idx), 32'(so), 32'(e.so));
      chk($sformatf("vec%0d Done", e.idx), 32'(done), 32'(e.done));
    end

    // WIDTH=2 serialise
    pat2 = 2'b10;
    @(negedge clk); rst2 = 1'b0; en2 = 1'b1; mode2 = LOAD; d2 = pat2;
    @(posedge clk); #1;
    chk("w2 load Q", 32'(q2), 32'(pat2));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); mode2 = SHR; serin2 = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("w2 shift%0d SerOut", i + 1), 32'(so2), 32'(pat2[i]));
      chk($sformatf("w2 shift%0d Done", i + 1), 32'(done2), (i == 1) ? 32'd1 : 32'd0);
    end
    chk("w2 final Q", 32'(q2), 32'd0);

    // WIDTH=13 serialise
    pat13 = 13'h1A5B;
    @(negedge clk); rst13 = 1'b0; en13 = 1'b1; mode13 = LOAD; d13 = pat13;
    @(posedge clk); #1;
    chk("w13 load Q", 32'(q13), 32'(pat13));
    for (int i = 0; i < 13; i++) begin
      @(negedge clk); mode13 = SHR; serin13 = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("w13 shift%0d SerOut", i + 1), 32'(so13), 32'(pat13[i]));
      chk($sformatf("w13 shift%0d Done", i + 1), 32'(done13), (i == 12) ? 32'd1 : 32'd0);
    end
    chk("w13 final Q", 32'(q13), 32'd0);
    @(negedge clk); mode13 = HOLD;
    @(posedge clk); #1;
    chk("w13 Done pulse width", 32'(done13), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/universal_shift_reg.md
# universal_shift_reg

Parametrised universal shift register with a shift-count tracker. It generalises the team's single-bit D flip-flop stages to a WIDTH-bit registered datapath with eight operating modes: hold, load, logical/arithmetic shifts, rotates and clear. A shift counter flags each completed full-width serial transfer. It is the storage/serialiser building block for the lab's later serial-transfer and display exercises.

## Interface
- WIDTH, 8, register width in bits; legal range WIDTH >= 2.
- Clk  input  1  rising-edge clock; the only clock.
- Reset  input  1  synchronous, active-high; sampled on rising Clk; overrides all other inputs.
- En  input  1  operation enable; low = hold everything.
- Mode  input  3  operation select (see Operation).
- D  input  WIDTH  parallel load data.
- SerIn  input  1  serial fill bit for logical shifts.
- Q  output  WIDTH  register contents.
- SerOut  output  1  last bit shifted or rotated out.
- Done  output  1  one-cycle pulse after every WIDTH-th shift/rotate.

## Operation
- Internal shift counter Cnt, width $clog2(WIDTH+1), range 0..WIDTH-1.
- Priority per rising edge: Reset > En=0 > Mode.
- Reset: Q=0, SerOut=0, Done=0, Cnt=0.
- En=0: Q, SerOut and Cnt hold; Done=0.
- En=1, by Mode:
  - 000 hold: Q, SerOut and Cnt hold; Done=0.
  - 001 load: Q=D; Cnt=0; Done=0; SerOut holds.
  - 010 shift right: Q={SerIn, Q[WIDTH-1:1]}; SerOut=old Q[0].
  - 011 shift left: Q={Q[WIDTH-2:0], SerIn}; SerOut=old Q[WIDTH-1].
  - 100 rotate right: Q={Q[0], Q[WIDTH-1:1]}; SerOut=old Q[0].
  - 101 rotate left: Q={Q[WIDTH-2:0], Q[WIDTH-1]}; SerOut=old Q[WIDTH-1].
  - 110 arithmetic shift right: Q={Q[WIDTH-1], Q[WIDTH-1:1]}; SerOut=old Q[0].
  - 111 clear: Q=0; Cnt=0; Done=0; SerOut=0.
- Modes 010–110 are shift operations:
  - If Cnt==WIDTH-1: Cnt wraps to 0 and Done=1.
  - Otherwise: Cnt=Cnt+1 and Done=0.
- Mixed shift modes all count toward the same Cnt; direction changes do not reset it.
- Load or clear mid-transfer aborts the count; no Done for the partial transfer.
- Hold or En=0 mid-transfer pauses Cnt; shifting resumes the count where it stopped.

## Timing
- All outputs are registered and update only on the rising Clk edge; there is no combinational input-to-output path.
- Latency is one cycle: inputs sampled at edge N appear on Q/SerOut/Done after edge N.
- Done is high for exactly one cycle, following the edge that performed the WIDTH-th counted shift.
- Continuous shifting produces Done after edges WIDTH, 2·WIDTH, …, with no gap.
- Reset asserted mid-transfer: outputs reach reset values after that edge. The first shift after Reset deasserts counts as shift 1.
- Reset and En=1 with any Mode in the same cycle: Reset wins.
- D, SerIn and Mode are don't-care when En=0 or Reset=1.

## Test plan
- Reset / load: WIDTH=8, Reset=1 for 2 cycles -> Q=8'h00, SerOut=0, Done=0. Then En=1, Mode=001, D=8'hA5 -> Q=8'hA5 one edge later, Done=0.
- Serialise: load 8'hA5, then 8 cycles of Mode=010, SerIn=0:
  - SerOut sequence is 1,0,1,0,0,1,0,1.
  - Q=8'h00 after edge 8.
  - Done=1 only after edge 8.
- Rotates / arithmetic shift:
  - Load 8'h81, Mode=101 once -> Q=8'h03, SerOut=1.
  - Mode=100 once -> Q=8'h81.
  - Load 8'h80, Mode=110 three times -> Q=8'hF0, SerOut=0.
- Pause and abort:
  - 5 shifts, 3 cycles En=0, 3 more shifts -> Done after the 8th shift only; Q and Cnt frozen during En=0.
  - 5 shifts, then load, then 8 shifts -> Done only after the 8th post-load shift.
- Continuous / reset mid-op:
  - 16 back-to-back Mode=011 shifts -> Done pulses after edges 8 and 16, each 1 cycle wide.
  - Reset asserted after shift 4 -> Q=0, Done=0; 8 further shifts -> Done after the 8th.
- Parameter sweep: repeat the serialise test with WIDTH=2 and WIDTH=13 -> Done after the 2nd and 13th shift respectively; SerOut reproduces the loaded pattern LSB-first.
